// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 serial receiver that rebuilds 64-bit words (first byte in
// the MSB) and presents them on an AXI-Stream master, with resync on errors.

module uart_word_rx #(
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale,
  input  logic        rxd,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        rx_busy,
  output logic        frame_error,
  output logic        overrun_error,
  output logic        timeout_error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [31:0] TMO_K = 32'(TIMEOUT_BITS);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        hist_q, hist_d;
  logic [1:0]  state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] pre_q, pre_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [55:0] word_q, word_d;
  logic [31:0] tmo_q, tmo_d;
  logic [63:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        to_q, to_d;

  logic [15:0] pre_eff;
  logic [18:0] bit_t;
  logic [31:0] tmo_lim;
  logic        start_edge;
  logic        expire;
  logic        byte_good;
  logic        word_done;

  assign pre_eff    = (prescale == 16'd0) ? 16'd1 : prescale;
  assign bit_t      = {pre_q, 3'b000};
  assign tmo_lim    = TMO_K * {13'd0, bit_t};
  assign start_edge = hist_q && !sync2_q;
  assign expire     = (cnt_q == 19'd0);

  always_comb begin
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    hist_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pre_d      = pre_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    tmo_d      = tmo_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    to_d       = 1'b0;
    byte_good  = 1'b0;
    word_done  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
          pre_d   = pre_eff;
          cnt_d   = {1'b0, pre_eff, 2'b00} - 19'd1;
        end
      end
      S_START: begin
        if (expire) begin
          if (!sync2_q) begin
            state_d   = S_DATA;
            cnt_d     = bit_t - 19'd1;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_DATA: begin
        if (expire) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = bit_t - 19'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_STOP: begin
        if (expire) begin
          state_d = S_IDLE;
          if (sync2_q) begin
            byte_good = 1'b1;
          end else begin
            fe_d       = 1'b1;
            byte_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Older bytes shift up; after 7 shifts byte 0 sits at the top.
    if (byte_good) begin
      word_d = {word_q[47:0], shift_q};
      if (byte_idx_q == 3'd7) begin
        word_done  = 1'b1;
        byte_idx_d = 3'd0;
      end else begin
        byte_idx_d = byte_idx_q + 3'd1;
      end
    end

    if (word_done) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = {word_q, shift_q};
        tvalid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    // Inter-byte watchdog; any start edge clears it.
    if (state_q == S_IDLE && byte_idx_q != 3'd0 && !start_edge) begin
      if (tmo_q >= tmo_lim - 32'd1) begin
        to_d       = 1'b1;
        byte_idx_d = 3'd0;
        tmo_d      = 32'd0;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end else begin
      tmo_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      hist_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= 19'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      pre_q      <= 16'd1;
      byte_idx_q <= 3'd0;
      word_q     <= 56'd0;
      tmo_q      <= 32'd0;
      tdata_q    <= 64'd0;
      tvalid_q   <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pre_q      <= pre_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      to_q       <= to_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign rx_busy       = (state_q != S_IDLE);
  assign frame_error   = fe_q;
  assign overrun_error = ov_q;
  assign timeout_error = to_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: random and directed serial traffic against a byte-level
// word/overrun/timeout model; one negedge process compares every cycle.

module tb_uart_word_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prescale;
  logic        rxd;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        rx_busy;
  logic        frame_error;
  logic        overrun_error;
  logic        timeout_error;

  always #5 clk = ~clk;

  uart_word_rx #(.TIMEOUT_BITS(40)) dut (
    .clk           (clk),
    .rst           (rst),
    .prescale      (prescale),
    .rxd           (rxd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rx_busy       (rx_busy),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .timeout_error (timeout_error)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rst_seen;

  // model state
  logic [63:0] exp_q[$];
  logic [7:0]  part[8];
  int          nbytes = 0;
  bit          model_full = 0;
  int          exp_fe = 0, exp_ov = 0, exp_to = 0;

  // observations
  int          obs_fe = 0, obs_ov = 0, obs_to = 0;
  int          beats = 0, tv_cycles = 0, busy_cycles = 0, to_cyc = 0;
  logic [63:0] last_beat = '0;
  bit          prev_hold = 0;
  logic [63:0] prev_data = '0;
  int          frame_end = 0;
  int          T = 16;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_seen = rst;
  end

  initial forever begin
    @(negedge clk);
    if (rst_seen === 1'b1) begin
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_flags", 64'({m_axis_tvalid, rx_busy, frame_error,
                             overrun_error, timeout_error}), 64'd0);
      prev_hold = 0;
    end else begin
      if (frame_error) obs_fe++;
      if (overrun_error) obs_ov++;
      if (timeout_error) begin
        obs_to++;
        to_cyc = cyc;
      end
      if (frame_error || overrun_error || timeout_error)
        check("pulse_exclusive",
              64'(int'(frame_error) + int'(overrun_error)
                  + int'(timeout_error)), 64'd1);
      if (m_axis_tvalid) tv_cycles++;
      if (rx_busy) busy_cycles++;
      if (prev_hold) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", m_axis_tdata, prev_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        last_beat = m_axis_tdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none",
                   m_axis_tdata);
        end else begin
          check("beat_data", m_axis_tdata, exp_q.pop_front());
        end
      end
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void set_prescale(input logic [15:0] p);
    prescale = p;
    T = ((p == 16'd0) ? 1 : int'(p)) * 8;
  endfunction

  function automatic void set_ready(input bit r);
    m_axis_tready = r;
    if (r) model_full = 0;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    nbytes = 0;
    model_full = 0;
  endfunction

  function automatic void model_gap(input int bits);
    if (nbytes != 0 && bits >= 45) begin
      exp_to++;
      nbytes = 0;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] d, input bit good);
    logic [63:0] w;
    if (!good) begin
      exp_fe++;
      nbytes = 0;
      return;
    end
    part[nbytes] = d;
    nbytes++;
    if (nbytes == 8) begin
      nbytes = 0;
      w = '0;
      for (int k = 0; k < 8; k++) w[63 - 8*k -: 8] = part[k];
      if (model_full && !m_axis_tready) begin
        exp_ov++;
      end else begin
        exp_q.push_back(w);
        model_full = !m_axis_tready;
      end
    end
  endfunction

  // gap in bit periods; rdy<0 leaves tready alone
  task automatic send_frame(input logic [7:0] d, input bit good,
                            input int gap, input int rdy);
    model_gap(gap);
    rxd = 1'b1;
    if (gap > 0) tick(gap * T);
    rxd = 1'b0;
    tick(T / 2);
    if (rdy >= 0) set_ready(rdy != 0);
    tick(T - T / 2);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(T);
    end
    rxd = good;
    tick(T / 2);
    model_byte(d, good);
    tick(T - T / 2);
    frame_end = cyc;
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] b0, input int gap,
                           input int rdy);
    for (int i = 0; i < 8; i++)
      send_frame(b0 + 8'(i), 1'b1, (i == 0) ? gap : 1, (i == 0) ? rdy : -1);
  endtask

  task automatic idle_bits(input int bits);
    model_gap(bits);
    rxd = 1'b1;
    tick(bits * T);
  endtask

  task automatic random_block(input int frames);
    bit prev_bad = 0;
    for (int f = 0; f < frames; f++) begin
      logic [7:0] d;
      bit good;
      int gap;
      d = 8'($urandom);
      good = ($urandom_range(0, 15) != 0);
      gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(45, 50))
                                         : int'($urandom_range(0, 6));
      if (prev_bad && gap == 0) gap = 1;
      send_frame(d, good, gap, int'($urandom_range(0, 1)));
      prev_bad = !good;
    end
  endtask

  int fe0, ov0, to0, bt0, tv0, bz0, tf;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    set_prescale(16'd2);
    m_axis_tready = 1'b0;
    tick(5);
    rst = 1'b0;
    model_reset();
    tick(10);
    check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("idle_busy", 64'(rx_busy), 64'd0);

    // 1: one word, tready high
    tv0 = tv_cycles; bt0 = beats;
    send_word(8'h01, 2, 1);
    tick(40);
    check("t1_data", last_beat, 64'h0102030405060708);
    check("t1_beats", 64'(beats - bt0), 64'd1);
    check("t1_tvalid_cycles", 64'(tv_cycles - tv0), 64'd1);
    check("t1_errs", 64'(obs_fe + obs_ov + obs_to), 64'd0);

    // 2: two words into a stalled output
    ov0 = obs_ov; bt0 = beats;
    send_word(8'h11, 2, 0);
    send_word(8'h21, 2, -1);
    tick(20);
    check("t2_overrun", 64'(obs_ov - ov0), 64'd1);
    check("t2_held_data", m_axis_tdata, 64'h1112131415161718);
    check("t2_held_valid", 64'(m_axis_tvalid), 64'd1);
    set_ready(1);
    tick(20);
    check("t2_beats", 64'(beats - bt0), 64'd1);
    check("t2_data", last_beat, 64'h1112131415161718);
    check("t2_drained", 64'(m_axis_tvalid), 64'd0);

    // 3: framing error mid-word
    fe0 = obs_fe;
    send_frame(8'h01, 1'b1, 2, 1);
    send_frame(8'h02, 1'b1, 1, -1);
    send_frame(8'h03, 1'b0, 1, -1);
    send_word(8'hA1, 2, -1);
    tick(40);
    check("t3_frame_err", 64'(obs_fe - fe0), 64'd1);
    check("t3_data", last_beat, 64'hA1A2A3A4A5A6A7A8);

    // 4: inter-byte timeout
    to0 = obs_to;
    send_frame(8'h01, 1'b1, 2, 1);
    send_frame(8'h02, 1'b1, 1, -1);
    send_frame(8'h03, 1'b1, 1, -1);
    tf = frame_end;
    send_word(8'hB1, 45, -1);
    tick(40);
    check("t4_timeout", 64'(obs_to - to0), 64'd1);
    check("t4_timing", 64'((to_cyc - tf) >= 620 && (to_cyc - tf) <= 650),
          64'd1);
    check("t4_data", last_beat, 64'hB1B2B3B4B5B6B7B8);

    // 5: short low glitch
    fe0 = obs_fe; ov0 = obs_ov; to0 = obs_to; bz0 = busy_cycles;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(40);
    check("t5_busy_len",
          64'((busy_cycles - bz0) >= 6 && (busy_cycles - bz0) <= 12), 64'd1);
    check("t5_no_err", 64'((obs_fe - fe0) + (obs_ov - ov0) + (obs_to - to0)),
          64'd0);

    // 6: reset during the 5th byte
    for (int i = 0; i < 4; i++)
      send_frame(8'h51 + 8'(i), 1'b1, 2, -1);
    rxd = 1'b1;
    tick(2 * T);
    rxd = 1'b0;
    tick(T);
    rxd = 1'b1;
    tick(2 * T);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(12 * T);
    send_word(8'hC1, 2, 1);
    tick(40);
    check("t6_data", last_beat, 64'hC1C2C3C4C5C6C7C8);

    // random traffic across prescale settings
    random_block(40);
    idle_bits(60);
    set_prescale(16'd1);
    random_block(40);
    idle_bits(60);
    set_prescale(16'd0);
    random_block(40);
    idle_bits(60);
    set_prescale(16'd2);
    random_block(30);
    set_ready(1);
    idle_bits(60);

    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_frame_errs", 64'(obs_fe), 64'(exp_fe));
    check("end_overruns", 64'(obs_ov), 64'(exp_ov));
    check("end_timeouts", 64'(obs_to), 64'(exp_to));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
